// File: rtl/present_mask_pkg.sv
// Shared constants, FSM state encoding and term indexing for the masked PRESENT S-box.
package present_mask_pkg;

   localparam int unsigned N_SHARES        = 3;
   localparam int unsigned NF_TERMS        = 27;
   localparam int unsigned TERMS_PER_SHARE = 3;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_e;

   // Bit position of term i of share j for output bit k.
   function automatic int unsigned term_index(input int unsigned k,
                                              input int unsigned j,
                                              input int unsigned i);
      return N_SHARES * TERMS_PER_SHARE * k + TERMS_PER_SHARE * j + i;
   endfunction

endpackage

// File: rtl/present_cf_xor3.sv
// Per-output-bit share compressor: 9 NF terms (3 per share) to 3 output shares.
// With PRESENT_CF_REFRESH_EN defined, a refreshing variant is also provided.
module present_cf_xor3
   import present_mask_pkg::*;
(
   input  logic [N_SHARES*TERMS_PER_SHARE-1:0] terms,
   output logic [N_SHARES-1:0]                 shares_c
);

   // Each share only folds terms of its own share index, keeping non-completeness.
   always_comb begin
      shares_c = '0;
      for (int unsigned j = 0; j < N_SHARES; j++) begin
         shares_c[j] = ^terms[TERMS_PER_SHARE*j +: TERMS_PER_SHARE];
      end
   end

endmodule

`ifdef PRESENT_CF_REFRESH_EN
// Compressor with a registered 2-bit refresh mask: shares get r_a, r_b, r_a^r_b.
module present_cf_xor3_rf
   import present_mask_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load,
   input  logic [1:0]                          rnd,
   input  logic [N_SHARES*TERMS_PER_SHARE-1:0] terms,
   output logic [N_SHARES-1:0]                 shares_c
);

   logic [1:0]          rnd_q;
   logic [N_SHARES-1:0] raw_c;

   // Mask captured together with the term vector so both meet in the compress cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rnd_q <= '0;
      end else if (load) begin
         rnd_q <= rnd;
      end
   end

   present_cf_xor3 u_xor3 (
      .terms    (terms),
      .shares_c (raw_c)
   );

   assign shares_c = raw_c ^ {rnd_q[0] ^ rnd_q[1], rnd_q[1], rnd_q[0]};

endmodule
`endif

// File: rtl/present_nf_cf_compress.sv
// Receiving end of the 3-share PRESENT S-box nonlinear stage: registers the NF
// term vector, compresses it to 3 bits x 3 shares and collects NIBBLES results.
// Optional macro PRESENT_CF_REFRESH_EN adds a 6-bit rnd input for share refresh.
module present_nf_cf_compress
   import present_mask_pkg::*;
#(
   parameter int unsigned NIBBLES = 16,
   parameter int unsigned CW      = 4
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NF_TERMS-1:0]   in_terms,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3*NIBBLES-1:0]  out_s0,
   output logic [3*NIBBLES-1:0]  out_s1,
   output logic [3*NIBBLES-1:0]  out_s2,
   output logic                  busy
`ifdef PRESENT_CF_REFRESH_EN
   ,
   input  logic [5:0]            rnd
`endif
);

   localparam int unsigned OUT_BITS = 3;
   localparam int unsigned GRP_W    = N_SHARES * TERMS_PER_SHARE;
   localparam logic [0:0]  ST_COLLECT = COLLECT;
   localparam logic [0:0]  ST_FULL    = FULL;

   logic [NF_TERMS-1:0] t_q;
   logic                t_valid_q, t_valid_d;
   logic [0:0]          state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic                accept, consume, last;
   logic [OUT_BITS-1:0] sh0_c, sh1_c, sh2_c;

   assign consume   = t_valid_q && (state_q == ST_COLLECT);
   assign in_ready  = (state_q == ST_COLLECT) && (!t_valid_q || consume);
   assign accept    = in_valid && in_ready;
   assign last      = (count_q == CW'(NIBBLES - 1));
   assign out_valid = (state_q == ST_FULL);

   // One compressor per output bit, fed only from the registered terms.
   for (genvar k = 0; k < OUT_BITS; k++) begin : g_bit
      logic [N_SHARES-1:0] shk_c;
`ifdef PRESENT_CF_REFRESH_EN
      present_cf_xor3_rf u_cf (
         .clk      (clk),
         .rst      (rst),
         .load     (accept),
         .rnd      (rnd[2*k +: 2]),
         .terms    (t_q[term_index(k, 0, 0) +: GRP_W]),
         .shares_c (shk_c)
      );
`else
      present_cf_xor3 u_cf (
         .terms    (t_q[term_index(k, 0, 0) +: GRP_W]),
         .shares_c (shk_c)
      );
`endif
      assign sh0_c[k] = shk_c[0];
      assign sh1_c[k] = shk_c[1];
      assign sh2_c[k] = shk_c[2];
   end

   // Next-state logic for the FSM, slot counter and term-register flag.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      t_valid_d = t_valid_q;
      if (consume) begin
         t_valid_d = 1'b0;
         count_d   = last ? '0 : count_q + CW'(1);
         if (last) begin
            state_d = ST_FULL;
         end
      end
      if (accept) begin
         t_valid_d = 1'b1;
      end
      if ((state_q == ST_FULL) && out_ready) begin
         state_d = ST_COLLECT;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Term register, counter, busy flag and share-wise result buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         t_q       <= '0;
         t_valid_q <= 1'b0;
         count_q   <= '0;
         busy      <= 1'b0;
         out_s0    <= '0;
         out_s1    <= '0;
         out_s2    <= '0;
      end else begin
         if (accept) begin
            t_q <= in_terms;
         end
         t_valid_q <= t_valid_d;
         count_q   <= count_d;
         busy      <= t_valid_d || (state_d == ST_FULL) || (count_d != '0);
         if ((state_q == ST_FULL) && out_ready) begin
            out_s0 <= '0;
            out_s1 <= '0;
            out_s2 <= '0;
         end else if (consume) begin
            for (int unsigned n = 0; n < NIBBLES; n++) begin
               if (count_q == CW'(n)) begin
                  out_s0[OUT_BITS*n +: OUT_BITS] <= sh0_c;
                  out_s1[OUT_BITS*n +: OUT_BITS] <= sh1_c;
                  out_s2[OUT_BITS*n +: OUT_BITS] <= sh2_c;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_present_nf_cf_compress.sv
// Self-checking bench for present_nf_cf_compress (NIBBLES=16 and NIBBLES=1 instances).
module tb_present_nf_cf_compress;

   localparam int unsigned NIB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              in_valid, in_ready;
   logic [26:0]       in_terms;
   logic              out_valid, out_ready, busy;
   logic [3*NIB-1:0]  out_s0, out_s1, out_s2;
   logic [5:0]        rnd_tb;

   logic              v1_in_valid, v1_in_ready;
   logic [26:0]       v1_in_terms;
   logic              v1_out_valid, v1_out_ready, v1_busy;
   logic [2:0]        v1_s0, v1_s1, v1_s2;

   typedef struct packed {
      logic [2:0] s0;
      logic [2:0] s1;
      logic [2:0] s2;
      logic [2:0] u;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   present_nf_cf_compress #(.NIBBLES(NIB), .CW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_terms  (in_terms),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s0    (out_s0),
      .out_s1    (out_s1),
      .out_s2    (out_s2),
      .busy      (busy)
`ifdef PRESENT_CF_REFRESH_EN
      ,
      .rnd       (rnd_tb)
`endif
   );

   present_nf_cf_compress #(.NIBBLES(1), .CW(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v1_in_valid),
      .in_ready  (v1_in_ready),
      .in_terms  (v1_in_terms),
      .out_valid (v1_out_valid),
      .out_ready (v1_out_ready),
      .out_s0    (v1_s0),
      .out_s1    (v1_s1),
      .out_s2    (v1_s2),
      .busy      (v1_busy)
`ifdef PRESENT_CF_REFRESH_EN
      ,
      .rnd       (rnd_tb)
`endif
   );

   // Reference: shares from the term layout, refresh masks, and the unshared value.
   function automatic exp_t model(input logic [26:0] t, input logic [5:0] r);
      exp_t e;
      logic x0, x1, x2, a, b;
      e = '0;
      for (int k = 0; k < 3; k++) begin
         x0 = t[9*k + 0] ^ t[9*k + 1] ^ t[9*k + 2];
         x1 = t[9*k + 3] ^ t[9*k + 4] ^ t[9*k + 5];
         x2 = t[9*k + 6] ^ t[9*k + 7] ^ t[9*k + 8];
         a  = r[2*k];
         b  = r[2*k + 1];
         e.s0[k] = x0 ^ a;
         e.s1[k] = x1 ^ b;
         e.s2[k] = x2 ^ a ^ b;
         e.u[k]  = ^t[9*k +: 9];
      end
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive one vector for one cycle; on acceptance push its expected result.
   task automatic send(input logic [26:0] v, output bit acc);
      in_valid = 1'b1;
      in_terms = v;
      acc      = in_ready;
      if (acc) sb.push_back(model(v, rnd_tb));
      step();
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         if (out_valid) ok = 1'b1;
         else step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
      end
      n_checks++;
      if ((out_s0 | out_s1 | out_s2) !== '0) begin
         n_fail++;
         $display("FAIL reset_buffers: got %h/%h/%h want 0", out_s0, out_s1, out_s2);
      end
      n_checks++;
      if ({v1_in_ready, v1_out_valid, v1_busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_flags_n1: got %b want 100", {v1_in_ready, v1_out_valid, v1_busy});
      end
   endtask

   task automatic test_single_nibble();
      v1_out_ready = 1'b1;
      v1_in_valid  = 1'b1;
      v1_in_terms  = 27'h0000007;
      n_checks++;
      if (v1_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL n1_ready: got %b want 1", v1_in_ready);
      end
      step();
      v1_in_valid = 1'b0;
      n_checks++;
      if ({v1_out_valid, v1_busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL n1_t1: got vld/busy=%b want 01", {v1_out_valid, v1_busy});
      end
      step();
      n_checks++;
      if ({v1_out_valid, v1_in_ready, v1_s0, v1_s1, v1_s2} !== {2'b10, 3'b001, 3'b000, 3'b000}) begin
         n_fail++;
         $display("FAIL n1_result: got vld=%b rdy=%b s=%b/%b/%b want 1 0 001/000/000",
                  v1_out_valid, v1_in_ready, v1_s0, v1_s1, v1_s2);
      end
      step();
      n_checks++;
      if ({v1_out_valid, v1_s0} !== 4'b0000) begin
         n_fail++;
         $display("FAIL n1_pulse: got vld=%b s0=%b want 0 000", v1_out_valid, v1_s0);
      end
   endtask

   task automatic test_unshared();
      bit acc, ok;
      out_ready = 1'b1;
      for (int i = 0; i < NIB; i++) begin
         send(27'($urandom), acc);
         in_valid = 1'b0;
         n_checks++;
         if (!acc) begin
            n_fail++;
            $display("FAIL unsh_accept %0d: got in_ready=0 want 1", i);
         end
         step();
      end
      wait_out(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL unsh_timeout: got out_valid=0 want 1");
      end
      for (int n = 0; n < NIB; n++) begin
         exp_t e;
         logic [2:0] g0, g1, g2;
         e  = (sb.size() > 0) ? sb.pop_front() : 'x;
         g0 = out_s0[3*n +: 3];
         g1 = out_s1[3*n +: 3];
         g2 = out_s2[3*n +: 3];
         n_checks++;
         if ({g0, g1, g2, g0 ^ g1 ^ g2} !== e) begin
            n_fail++;
            $display("FAIL unsh_slot %0d: got %b/%b/%b u=%b want %b/%b/%b u=%b",
                     n, g0, g1, g2, g0 ^ g1 ^ g2, e.s0, e.s1, e.s2, e.u);
         end
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL unsh_pulse: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      bit acc, ok;
      logic [3*NIB-1:0] h0, h1, h2;
      out_ready = 1'b0;
      for (int i = 0; i < NIB + 1; i++) begin
         send(27'($urandom), acc);
         n_checks++;
         if (!acc) begin
            n_fail++;
            $display("FAIL bp_accept %0d: got in_ready=0 want 1", i);
         end
      end
      h0 = out_s0; h1 = out_s1; h2 = out_s2;
      in_terms = 27'($urandom);
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if ({in_ready, out_valid} !== 2'b01 || {out_s0, out_s1, out_s2} !== {h0, h1, h2}) begin
            n_fail++;
            $display("FAIL bp_hold cyc %0d: got rdy=%b vld=%b stable=%b want 0 1 1",
                     c, in_ready, out_valid, {out_s0, out_s1, out_s2} === {h0, h1, h2});
         end
         step();
      end
      for (int n = 0; n < NIB; n++) begin
         exp_t e;
         logic [2:0] g0, g1, g2;
         e  = (sb.size() > 0) ? sb.pop_front() : 'x;
         g0 = out_s0[3*n +: 3];
         g1 = out_s1[3*n +: 3];
         g2 = out_s2[3*n +: 3];
         n_checks++;
         if ({g0, g1, g2, g0 ^ g1 ^ g2} !== e) begin
            n_fail++;
            $display("FAIL bp_slot %0d: got %b/%b/%b want %b/%b/%b", n, g0, g1, g2, e.s0, e.s1, e.s2);
         end
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      step();
      n_checks++;
      if ({out_valid, out_s0, out_s1, out_s2} !== '0) begin
         n_fail++;
         $display("FAIL bp_clear: got vld=%b s0=%h want 0 0", out_valid, out_s0);
      end
      step();
      n_checks++;
      if (sb.size() == 0 || {out_s0[2:0], out_s1[2:0], out_s2[2:0]} !== {sb[0].s0, sb[0].s1, sb[0].s2}) begin
         n_fail++;
         $display("FAIL bp_held_slot0: got %b/%b/%b want vector 17 in slot 0",
                  out_s0[2:0], out_s1[2:0], out_s2[2:0]);
      end
      for (int i = 0; i < NIB - 1; i++) send(27'($urandom), acc);
      in_valid = 1'b0;
      wait_out(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_timeout: got out_valid=0 want 1");
      end
      for (int n = 0; n < NIB; n++) begin
         exp_t e;
         logic [2:0] g0, g1, g2;
         e  = (sb.size() > 0) ? sb.pop_front() : 'x;
         g0 = out_s0[3*n +: 3];
         g1 = out_s1[3*n +: 3];
         g2 = out_s2[3*n +: 3];
         n_checks++;
         if ({g0, g1, g2, g0 ^ g1 ^ g2} !== e) begin
            n_fail++;
            $display("FAIL bp_next_slot %0d: got %b/%b/%b want %b/%b/%b", n, g0, g1, g2, e.s0, e.s1, e.s2);
         end
      end
      step();
   endtask

   task automatic test_throughput();
      bit acc;
      out_ready = 1'b1;
      for (int i = 0; i < NIB; i++) begin
         send(27'($urandom), acc);
         n_checks++;
         if (!acc) begin
            n_fail++;
            $display("FAIL tp_ready %0d: got in_ready=0 want 1", i);
         end
         if (i == 0) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL tp_busy: got %b want 1", busy);
            end
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tp_early: got out_valid=%b at t+1 want 0", out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL tp_latency: got out_valid=%b at t+2 want 1", out_valid);
      end
      for (int n = 0; n < NIB; n++) begin
         exp_t e;
         logic [2:0] g0, g1, g2;
         e  = (sb.size() > 0) ? sb.pop_front() : 'x;
         g0 = out_s0[3*n +: 3];
         g1 = out_s1[3*n +: 3];
         g2 = out_s2[3*n +: 3];
         n_checks++;
         if ({g0, g1, g2, g0 ^ g1 ^ g2} !== e) begin
            n_fail++;
            $display("FAIL tp_slot %0d: got %b/%b/%b want %b/%b/%b", n, g0, g1, g2, e.s0, e.s1, e.s2);
         end
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tp_pulse: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit acc, ok;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) send(27'($urandom), acc);
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || {out_s0, out_s1, out_s2} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_state: got rdy/vld/busy=%b s0=%h want 100 0",
                  {in_ready, out_valid, busy}, out_s0);
      end
      for (int i = 0; i < NIB; i++) send(27'($urandom), acc);
      in_valid = 1'b0;
      wait_out(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rstmid_timeout: got out_valid=0 want 1");
      end
      for (int n = 0; n < NIB; n++) begin
         exp_t e;
         logic [2:0] g0, g1, g2;
         e  = (sb.size() > 0) ? sb.pop_front() : 'x;
         g0 = out_s0[3*n +: 3];
         g1 = out_s1[3*n +: 3];
         g2 = out_s2[3*n +: 3];
         n_checks++;
         if ({g0, g1, g2, g0 ^ g1 ^ g2} !== e) begin
            n_fail++;
            $display("FAIL rstmid_slot %0d: got %b/%b/%b want %b/%b/%b", n, g0, g1, g2, e.s0, e.s1, e.s2);
         end
      end
      step();
   endtask

`ifdef PRESENT_CF_REFRESH_EN
   task automatic test_refresh();
      bit acc, ok;
      out_ready = 1'b1;
      rnd_tb    = 6'b101101;
      for (int i = 0; i < NIB; i++) send(27'h0, acc);
      in_valid = 1'b0;
      rnd_tb   = 6'b000000;
      wait_out(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rf_timeout: got out_valid=0 want 1");
      end
      for (int n = 0; n < NIB; n++) begin
         logic [2:0] g0, g1, g2;
         g0 = out_s0[3*n +: 3];
         g1 = out_s1[3*n +: 3];
         g2 = out_s2[3*n +: 3];
         n_checks++;
         if ({g0, g1, g2, g0 ^ g1 ^ g2} !== {3'b011, 3'b110, 3'b101, 3'b000}) begin
            n_fail++;
            $display("FAIL rf_slot %0d: got %b/%b/%b want 011/110/101", n, g0, g1, g2);
         end
      end
      sb.delete();
      step();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_terms     = '0;
      out_ready    = 1'b1;
      v1_in_valid  = 1'b0;
      v1_in_terms  = '0;
      v1_out_ready = 1'b1;
      rnd_tb       = '0;
      @(negedge clk);
      test_reset();
      test_single_nibble();
      test_unshared();
      test_backpressure();
      test_throughput();
      test_reset_mid();
`ifdef PRESENT_CF_REFRESH_EN
      test_refresh();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/present_nf_cf_compress.md
Name: present_nf_cf_compress

Overview:
- Receiving end of the 3-share PRESENT S-box nonlinear stage.
- Accepts the 27-term partial-product vector from the NF coordinate-function stage and registers it as a mandatory glitch barrier.
- Compresses the 27 terms into 3 output bits × 3 shares, then collects NIBBLES consecutive results into share-wise buffers.
- Hands the full layer result to the pLayer datapath over a valid/ready interface.

Parameters:
- NIBBLES, 16, number of S-box evaluations collected per layer result (range 1–16).
- CW, 4, counter width; must satisfy 2^CW >= NIBBLES.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  term vector valid.
- in_ready  out  1  block can accept a term vector this cycle.
- in_terms  in  27  NF terms; bit 9k+3j+i is term i of share j for output bit k.
- out_valid  out  1  layer result available.
- out_ready  in  1  downstream accepts the result.
- out_s0, out_s1, out_s2  out  3*NIBBLES  share buffers; nibble n occupies bits [3n+2:3n].
- busy  out  1  high whenever the block holds data in the term register or the buffers.

Behaviour:
- Reset: in_ready=1, out_valid=0, busy=0, count=0, term register valid flag=0, all share buffers=0. All registers reset synchronously; the terms themselves reset to zero.
- Stage 1 (term register):
  - On in_valid && in_ready, latch in_terms and set t_valid.
  - No combinational path from in_terms to any later logic; the register is mandatory.
- Stage 2 (compress):
  - Share j of bit k = XOR of term[9k+3j], term[9k+3j+1], term[9k+3j+2].
  - Each share takes only terms indexed by d-share j, preserving non-completeness.
  - When t_valid and state=COLLECT, write the 3-bit share j into buffer j at slot count. Then count+1 and clear t_valid, unless a new accept occurs in the same cycle.
- in_ready = (state==COLLECT) && (!t_valid || stage 2 consumes this cycle). Back-to-back accepts give throughput of 1 vector per cycle.
- Latency: a vector accepted in cycle t is written to the buffers in cycle t+1. out_valid rises in cycle t+2 after the NIBBLES-th write.
- FSM:
  - COLLECT: on the write with count==NIBBLES-1, count wraps to 0 and the FSM goes to FULL.
  - FULL: out_valid=1, in_ready=0, buffers held stable. On out_valid && out_ready, go to COLLECT and clear the buffers in the same edge.
- Boundary conditions:
  - A vector accepted while the last nibble is still pending remains in the term register until the return to COLLECT; it is never lost.
  - out_ready held high in FULL gives a one-cycle out_valid pulse.
  - rst asserted mid-collection discards all partial data and the term register; out_valid stays 0.
  - NIBBLES=1: every vector produces a result and the FSM alternates COLLECT/FULL.
- Security: the three share buffers never mix; no XOR across shares anywhere in the block.

Optional Feature:
- PRESENT_CF_REFRESH_EN defined:
  - Adds input rnd (6 bits, 2 per output bit), sampled in the compress cycle.
  - Share0 ^= r_a, share1 ^= r_b, share2 ^= r_a^r_b per bit, where r_a = rnd[2k] and r_b = rnd[2k+1]. The unshared value is unchanged.
  - rnd is also registered before the XOR.
- Not defined: no rnd port; plain compression as above.

Decomposition:
- Shared package present_mask_pkg holds:
  - constants N_SHARES=3, NF_TERMS=27, TERMS_PER_SHARE=3;
  - state enum {COLLECT, FULL};
  - helper function term_index(k,j,i) returning 9k+3j+i.
- One natural sub-module: present_cf_xor3, a purely combinational 9-bit to 3-bit share compressor for one output bit. It is instantiated 3 times, and a variant with a registered refresh input is used when refresh is enabled.

Test Plan:
- Single vector, NIBBLES=1: in_terms=27'h0000007 → out_s0=3'b001, out_s1=0, out_s2=0, out_valid asserted 2 cycles after accept.
- Unshared correctness: 16 random vectors with out_ready=1 → out_s0^out_s1^out_s2 equals the XOR of each 9-term group per bit, for all 16 nibbles in the slot order they were accepted.
- Backpressure: hold out_ready=0 for 10 cycles in FULL while in_valid=1 → in_ready=0, outputs stable. Release out_ready → the held 17th vector lands in slot 0 of the next layer.
- Throughput: 16 vectors on consecutive cycles → in_ready never drops before the last accept; out_valid appears exactly 2 cycles after the 16th accept.
- Reset mid-operation: assert rst after 7 accepts → count=0, out_valid=0, buffers=0. The next 16 vectors produce a correct result.
- With PRESENT_CF_REFRESH_EN: all-zero terms, rnd=6'b101101 → recombined outputs=0, individual shares non-zero as specified.
